// File: rtl/i2c_passthru_bitrx.sv
// Source-side I2C bit receiver for a pass-through bridge: classifies each SCL-high bit as data/start/stop/error.
// Optional define I2C_PASSTHRU_BITRX_STRETCH_EN holds SCL low in ST_IDLE until i_start_rx.
module i2c_passthru_bitrx #(
    parameter int F_REF_T_SU_DAT       = 2,
    parameter int F_REF_T_LOW          = 38,
    parameter int WIDTH_F_REF_T_SU_DAT = 2,
    parameter int WIDTH_F_REF_T_LOW    = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_f_ref,
    input  logic i_start_rx,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl,
    output logic o_rx_sda_init_valid,
    output logic o_rx_sda_init,
    output logic o_rx_sda_mid_change,
    output logic o_rx_sda_final,
    output logic o_rx_done,
    output logic o_stop_det,
    output logic o_violation
);

    localparam int WSU = WIDTH_F_REF_T_SU_DAT;
    localparam int WLO = WIDTH_F_REF_T_LOW;
    localparam logic [WSU-1:0] SU_LOAD = WSU'(F_REF_T_SU_DAT);
    localparam logic [WSU-1:0] SU_ONE  = WSU'(1);
    localparam logic [WLO-1:0] LO_LOAD = WLO'(F_REF_T_LOW);
    localparam logic [WLO-1:0] LO_ONE  = WLO'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCL0_REL,
        ST_SCL1,
        ST_BUS_FREE,
        ST_VIOLATION
    } state_t;

    state_t         state, state_d;
    logic           init_valid, init_valid_d;
    logic           init, init_d;
    logic           mid, mid_d;
    logic           fin, fin_d;
    logic [1:0]     chg_cnt, chg_cnt_d;
    logic [WSU-1:0] su_cnt, su_cnt_d;
    logic [WLO-1:0] low_cnt, low_cnt_d;
    logic           sda_q, f_ref_q;
    logic           ref_pulse, sda_chg, go_rel;

    assign ref_pulse = i_f_ref & ~f_ref_q;
    assign sda_chg   = i_sda ^ sda_q;

`ifdef I2C_PASSTHRU_BITRX_STRETCH_EN
    assign go_rel = i_start_rx;
    assign o_scl  = (state != ST_IDLE);
`else
    logic unused_start_rx;
    assign unused_start_rx = i_start_rx;
    assign go_rel = 1'b1;
    assign o_scl  = 1'b1;
`endif

    always_comb begin
        state_d      = state;
        init_valid_d = init_valid;
        init_d       = init;
        mid_d        = mid;
        fin_d        = fin;
        chg_cnt_d    = chg_cnt;
        su_cnt_d     = su_cnt;
        low_cnt_d    = low_cnt;
        case (state)
            ST_IDLE: begin
                if (go_rel) begin
                    state_d      = ST_SCL0_REL;
                    init_d       = i_sda;
                    init_valid_d = 1'b0;
                    su_cnt_d     = SU_LOAD;
                end
            end
            ST_SCL0_REL: begin
                if (i_scl) begin
                    state_d      = ST_SCL1;
                    init_d       = i_sda;
                    fin_d        = i_sda;
                    init_valid_d = 1'b1;
                    chg_cnt_d    = 2'd0;
                    mid_d        = 1'b0;
                    low_cnt_d    = LO_LOAD;
                end else begin
                    init_d = i_sda;
                    if (sda_chg) begin
                        init_valid_d = 1'b0;
                        su_cnt_d     = SU_LOAD;
                    end else if (su_cnt == '0) begin
                        init_valid_d = 1'b1;
                    end else if (ref_pulse) begin
                        su_cnt_d = su_cnt - SU_ONE;
                        if (su_cnt == SU_ONE) init_valid_d = 1'b1;
                    end
                end
            end
            ST_SCL1: begin
                // SCL fall wins over a coincident SDA edge so final keeps the pre-fall level
                if (!i_scl) begin
                    state_d = ST_IDLE;
                end else if (sda_chg) begin
                    fin_d     = i_sda;
                    mid_d     = 1'b1;
                    low_cnt_d = LO_LOAD;
                    if (chg_cnt == 2'd2) state_d = ST_VIOLATION;
                    else                 chg_cnt_d = chg_cnt + 2'd1;
                end else if (mid && i_sda) begin
                    if (low_cnt == '0 || (ref_pulse && low_cnt == LO_ONE)) begin
                        state_d   = ST_BUS_FREE;
                        init_d    = 1'b1;
                        fin_d     = 1'b1;
                        low_cnt_d = '0;
                    end else if (ref_pulse) begin
                        low_cnt_d = low_cnt - LO_ONE;
                    end
                end
            end
            ST_BUS_FREE: begin
                if (!i_scl) begin
                    state_d = ST_VIOLATION;
                end else if (sda_chg && !i_sda) begin
                    state_d   = ST_SCL1;
                    init_d    = 1'b1;
                    fin_d     = 1'b0;
                    chg_cnt_d = 2'd1;
                    mid_d     = 1'b1;
                    low_cnt_d = LO_LOAD;
                end
            end
            ST_VIOLATION: state_d = ST_VIOLATION;
            default:      state_d = ST_VIOLATION;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_SCL1;
            init_valid <= 1'b1;
            init       <= 1'b1;
            mid        <= 1'b0;
            fin        <= 1'b1;
            chg_cnt    <= 2'd0;
            su_cnt     <= '0;
            low_cnt    <= '0;
            sda_q      <= i_sda;
            f_ref_q    <= 1'b1;
        end else begin
            state      <= state_d;
            init_valid <= init_valid_d;
            init       <= init_d;
            mid        <= mid_d;
            fin        <= fin_d;
            chg_cnt    <= chg_cnt_d;
            su_cnt     <= su_cnt_d;
            low_cnt    <= low_cnt_d;
            sda_q      <= i_sda;
            f_ref_q    <= i_f_ref;
        end
    end

    assign o_rx_sda_init_valid = init_valid;
    assign o_rx_sda_init       = init;
    assign o_rx_sda_mid_change = mid;
    assign o_rx_sda_final      = fin;
    assign o_rx_done           = (state == ST_IDLE) || (state == ST_BUS_FREE);
    assign o_stop_det          = (state == ST_BUS_FREE);
    assign o_violation         = (state == ST_VIOLATION);

endmodule

// File: tb/tb_i2c_passthru_bitrx.sv
// Bench for i2c_passthru_bitrx: completed bit descriptors are checked against a queue of expected bits.
module tb_i2c_passthru_bitrx;

    logic clk = 1'b0, rst = 1'b1, f_ref = 1'b0, start_rx = 1'b0, scl = 1'b1, sda = 1'b1;
    logic o_scl, o_valid, o_init, o_mid, o_final, o_done, o_stop, o_viol;

    typedef struct packed { logic init; logic mid; logic fin; } bit_t;
    bit_t exp_q[$];
    int   passed = 0, total = 0;

`ifdef I2C_PASSTHRU_BITRX_STRETCH_EN
    localparam logic IDLE_SCL = 1'b0;
`else
    localparam logic IDLE_SCL = 1'b1;
`endif

    i2c_passthru_bitrx dut (
        .i_clk(clk), .i_rst(rst), .i_f_ref(f_ref), .i_start_rx(start_rx),
        .i_scl(scl), .i_sda(sda), .o_scl(o_scl),
        .o_rx_sda_init_valid(o_valid), .o_rx_sda_init(o_init),
        .o_rx_sda_mid_change(o_mid), .o_rx_sda_final(o_final),
        .o_rx_done(o_done), .o_stop_det(o_stop), .o_violation(o_viol)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic ref_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            f_ref = 1'b1; tick();
            f_ref = 1'b0; tick();
        end
    endtask

    task automatic begin_bit;
        start_rx = 1'b1; tick(); start_rx = 1'b0;
    endtask

    // Waits for o_rx_done after SCL has been dropped; reports cycles taken
    task automatic wait_done(output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (o_done) begin ok = 1'b1; cyc = i; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; scl = 1'b1; sda = 1'b1; tick(); tick();
        total++; if (o_scl !== 1'b1)   $display("FAIL rst_scl got %b exp 1", o_scl);   else passed++;
        total++; if (o_valid !== 1'b1) $display("FAIL rst_valid got %b exp 1", o_valid); else passed++;
        total++; if ({o_init, o_mid, o_final} !== 3'b101) $display("FAIL rst_desc got %b exp 101", {o_init, o_mid, o_final}); else passed++;
        total++; if ({o_done, o_stop, o_viol} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {o_done, o_stop, o_viol}); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_data_bit;
        bit ok; int cyc; bit_t e;
        exp_q.push_back('{init: 1'b1, mid: 1'b0, fin: 1'b1});
        scl = 1'b0; wait_done(ok, cyc);
        e = exp_q.pop_front();
        total++; if (!ok || cyc != 1) $display("FAIL done_latency got ok=%0d cyc=%0d exp 1", ok, cyc); else passed++;
        total++; if ({o_init, o_mid, o_final} !== e) $display("FAIL idle_bit got %b exp %b", {o_init, o_mid, o_final}, e); else passed++;
        begin_bit();
        total++; if (o_valid !== 1'b0) $display("FAIL rel_valid_clear got %b exp 0", o_valid); else passed++;
        sda = 1'b0; tick(); ref_pulses(3);
        total++; if ({o_valid, o_init} !== 2'b10) $display("FAIL setup_valid got %b exp 10", {o_valid, o_init}); else passed++;
        total++; if (o_scl !== 1'b1 || o_done !== 1'b0) $display("FAIL rel_out got scl=%b done=%b exp 1/0", o_scl, o_done); else passed++;
        exp_q.push_back('{init: 1'b0, mid: 1'b0, fin: 1'b0});
        scl = 1'b1; tick();
        total++; if (o_done !== 1'b0) $display("FAIL scl1_done got %b exp 0", o_done); else passed++;
        scl = 1'b0; wait_done(ok, cyc);
        e = exp_q.pop_front();
        total++; if (!ok || {o_init, o_mid, o_final} !== e) $display("FAIL data_bit got ok=%0d %b exp %b", ok, {o_init, o_mid, o_final}, e); else passed++;
        total++; if (o_scl !== IDLE_SCL) $display("FAIL idle_scl got %b exp %b", o_scl, IDLE_SCL); else passed++;
    endtask

    task automatic test_setup_restart;
        bit ok; int cyc; bit_t e;
        begin_bit(); ref_pulses(1);
        sda = 1'b1; tick();
        total++; if (o_valid !== 1'b0) $display("FAIL restart_v0 got %b exp 0", o_valid); else passed++;
        ref_pulses(1);
        total++; if (o_valid !== 1'b0) $display("FAIL restart_v1 got %b exp 0", o_valid); else passed++;
        ref_pulses(1);
        total++; if ({o_valid, o_init} !== 2'b11) $display("FAIL restart_v2 got %b exp 11", {o_valid, o_init}); else passed++;
        exp_q.push_back('{init: 1'b1, mid: 1'b0, fin: 1'b1});
        scl = 1'b1; tick(); scl = 1'b0; wait_done(ok, cyc);
        e = exp_q.pop_front();
        total++; if (!ok || {o_init, o_mid, o_final} !== e) $display("FAIL restart_bit got ok=%0d %b exp %b", ok, {o_init, o_mid, o_final}, e); else passed++;
    endtask

    task automatic test_stop;
        bit_t e;
        begin_bit(); sda = 1'b0; tick(); ref_pulses(3);
        scl = 1'b1; tick();
        exp_q.push_back('{init: 1'b1, mid: 1'b1, fin: 1'b1});
        sda = 1'b1; tick();
        ref_pulses(37);
        total++; if (o_stop !== 1'b0) $display("FAIL stop_early got %b exp 0", o_stop); else passed++;
        ref_pulses(3);
        e = exp_q.pop_front();
        total++; if (!o_done || {o_init, o_mid, o_final} !== e) $display("FAIL stop_bit got done=%b %b exp %b", o_done, {o_init, o_mid, o_final}, e); else passed++;
        total++; if ({o_stop, o_scl, o_viol} !== 3'b110) $display("FAIL stop_flags got %b exp 110", {o_stop, o_scl, o_viol}); else passed++;
    endtask

    task automatic test_start_after_free;
        bit ok; int cyc; bit_t e;
        sda = 1'b0; tick();
        total++; if ({o_init, o_mid, o_final} !== 3'b110) $display("FAIL start_desc got %b exp 110", {o_init, o_mid, o_final}); else passed++;
        total++; if ({o_done, o_stop} !== 2'b00) $display("FAIL start_flags got %b exp 00", {o_done, o_stop}); else passed++;
        exp_q.push_back('{init: 1'b1, mid: 1'b1, fin: 1'b0});
        scl = 1'b0; wait_done(ok, cyc);
        e = exp_q.pop_front();
        total++; if (!ok || {o_init, o_mid, o_final} !== e) $display("FAIL start_bit got ok=%0d %b exp %b", ok, {o_init, o_mid, o_final}, e); else passed++;
    endtask

    task automatic test_scl_fall_priority;
        bit ok; int cyc; bit_t e;
        begin_bit(); sda = 1'b1; tick(); ref_pulses(2);
        scl = 1'b1; tick();
        exp_q.push_back('{init: 1'b1, mid: 1'b0, fin: 1'b1});
        scl = 1'b0; sda = 1'b0; wait_done(ok, cyc);
        e = exp_q.pop_front();
        total++; if (!ok || {o_init, o_mid, o_final} !== e) $display("FAIL fall_prio got ok=%0d %b exp %b", ok, {o_init, o_mid, o_final}, e); else passed++;
    endtask

    task automatic test_glitch;
        begin_bit(); ref_pulses(2);
        scl = 1'b1; tick();
        sda = 1'b1; tick(); sda = 1'b0; tick();
        total++; if (o_viol !== 1'b0) $display("FAIL glitch_two got %b exp 0", o_viol); else passed++;
        sda = 1'b1; tick();
        total++; if ({o_viol, o_done, o_scl} !== 3'b101) $display("FAIL glitch_three got %b exp 101", {o_viol, o_done, o_scl}); else passed++;
        scl = 1'b0; start_rx = 1'b1; ref_pulses(3); scl = 1'b1; sda = 1'b0; tick(); start_rx = 1'b0; sda = 1'b1; tick();
        total++; if (o_viol !== 1'b1) $display("FAIL viol_hold got %b exp 1", o_viol); else passed++;
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if ({o_viol, o_scl, o_init, o_final, o_valid, o_done} !== 6'b011110) $display("FAIL viol_reset got %b exp 011110", {o_viol, o_scl, o_init, o_final, o_valid, o_done}); else passed++;
    endtask

    task automatic test_free_scl_low;
        sda = 1'b0; tick(); sda = 1'b1; tick(); ref_pulses(38);
        total++; if (o_stop !== 1'b1) $display("FAIL free_reach got %b exp 1", o_stop); else passed++;
        scl = 1'b0; tick();
        total++; if ({o_viol, o_stop} !== 2'b10) $display("FAIL free_scl_low got %b exp 10", {o_viol, o_stop}); else passed++;
        scl = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
        total++; if (o_viol !== 1'b0) $display("FAIL free_reset got %b exp 0", o_viol); else passed++;
    endtask

    initial begin
        test_reset();
        test_data_bit();
        test_setup_restart();
        test_stop();
        test_start_after_free();
        test_scl_fall_priority();
        test_glitch();
        test_free_scl_low();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
